dp_sequencer: RTL and testbench
===============================

# dp_sequencer

Multi-cycle control unit that fetches 16-bit instructions, decodes them, and sequences the `data_path` block through operand read, ALU execution, register writeback and PC update. It sits between the instruction memory and `data_path` and drives every `data_path` control input. It observes only the datapath's completion strobe, and uses a timeout to catch a stalled datapath.

## Interface
Parameters:
- `DWIDTH`, 16, instruction and datapath word width.
- `TIMEOUT`, 15, maximum cycles to wait for `dp_done` before entering ERR; must be 1..255.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: level start/resume request.
- `instr` input DWIDTH: instruction word from instruction memory.
- `instr_valid` input 1: `instr` valid this cycle.
- `instr_req` output 1: fetch request.
- `dp_done` input 1: `data_path` `en_out` (ALU result ready).
- `en_in` output 1: datapath operation start pulse.
- `en_pc_pulse` output 1: PC update pulse.
- `pc_ctrl` output 2: 00 hold, 01 PC+1, 10 load `offset_addr`, 11 hold.
- `offset_addr` output 8: jump target, equal to IR[7:0].
- `offset` output 8: immediate, equal to IR[7:0].
- `rd`, `rs` outputs 2: IR[11:10] and IR[9:8].
- `alu_in_sel` output 1: 0 selects register `rs`, 1 selects immediate.
- `alu_func` output 3: ALU function.
- `reg_en` output 4: one-hot register write enable.
- `busy` output 1: high in any state except IDLE, HALT and ERR.
- `halted` output 1: high in HALT.
- `error` output 1: high in ERR.

## Operation
- Instruction register (IR) latches `instr` only in FETCH when `instr_valid`=1.
- Opcode is IR[15:12]:
  - 0000 NOP.
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR: `alu_func` = opcode-1, `alu_in_sel`=0.
  - 1000 ADDI: `alu_func`=000, `alu_in_sel`=1.
  - 1001 SUBI: `alu_func`=001, `alu_in_sel`=1.
  - 1100 JMP.
  - 1111 HALT.
  - Any other opcode is illegal.
- FSM states: IDLE, FETCH, DECODE, EXEC, WAIT, WB, PCUP, HALT, ERR.
- IDLE: `start`=1 -> FETCH.
- FETCH: `instr_req`=1 -> DECODE once `instr_valid`=1, otherwise stay.
- DECODE, by opcode:
  - ALU op -> EXEC.
  - NOP -> PCUP with `pc_ctrl`=01.
  - JMP -> PCUP with `pc_ctrl`=10.
  - HALT -> HALT.
  - Illegal -> ERR.
- EXEC: `en_in`=1 for exactly one cycle -> WAIT; clear the wait counter.
- WAIT:
  - `dp_done`=1 -> WB.
  - Otherwise increment the counter; counter == TIMEOUT-1 with no `dp_done` -> ERR.
- WB: `reg_en` = one-hot(`rd`) for one cycle (rd=2 -> 4'b0100) -> PCUP with `pc_ctrl`=01.
- PCUP: `en_pc_pulse`=1 for one cycle -> FETCH.
- HALT: `halted`=1; `start`=1 -> PCUP with `pc_ctrl`=01, i.e. resume at the next address.
- ERR: `error`=1; leaves only on reset. `start` is ignored.
- Control outputs are registered copies of IR fields:
  - `rd`, `rs`, `offset`, `offset_addr`, `alu_func`, `alu_in_sel` are held stable from EXEC entry through the end of WB.
  - `pc_ctrl` is valid in every cycle of PCUP and is 00 elsewhere.
- `dp_done` outside WAIT is ignored.

## Timing
- Reset: every output is 0, FSM is IDLE, IR is 0, counter is 0. `pc_ctrl`=00 and `reg_en`=0000.
- Reset mid-operation forces IDLE immediately; no `en_in`, `en_pc_pulse` or `reg_en` glitch is emitted after `rst_n` falls.
- `start` sampled in IDLE: FETCH is entered in the next cycle, and `instr_req` rises that cycle.
- `instr_valid` in the same cycle `instr_req` first rises is accepted. Minimum fetch = 1 cycle.
- Best-case ALU instruction is 6 cycles: FETCH, DECODE, EXEC, WAIT(`dp_done` present on the first cycle), WB, PCUP.
- NOP and JMP take 3 cycles: FETCH, DECODE, PCUP.
- Timeout: ERR is entered on the edge after the TIMEOUT-th consecutive WAIT cycle without `dp_done`.
- `dp_done` in that last WAIT cycle wins over the timeout and goes to WB.
- `en_in`, `en_pc_pulse` and `reg_en` are never high in the same cycle.
- `instr_req` is low in every state except FETCH.
- All outputs are driven from flops or decoded from state plus IR only; there is no combinational path from an input to an output.

## Test plan
- Reset then `start`; memory returns ADD r1,r2 (0x1600) with 1-cycle `instr_valid`; `dp_done` 2 cycles after `en_in` -> in EXEC `alu_func`=000, `rd`=1, `rs`=2, `alu_in_sel`=0; then `reg_en`=0010 for one cycle, then `en_pc_pulse` with `pc_ctrl`=01; total 7 cycles.
- ADDI r3,#0x5A (0x8C5A) -> `alu_in_sel`=1, `offset`=0x5A, `reg_en`=1000.
- JMP 0x3C (0xC03C) -> no `en_in`; `en_pc_pulse`=1 with `pc_ctrl`=10 and `offset_addr`=0x3C, exactly 2 cycles after `instr_valid`.
- HALT (0xF000) -> `halted`=1, `busy`=0, stays until `start`; `start` -> one `en_pc_pulse` with `pc_ctrl`=01, then `instr_req`.
- ALU op with `dp_done` never asserted, TIMEOUT=15 -> `error`=1 after exactly 15 WAIT cycles and stays high with `start` toggling. Repeat with `dp_done` on the 15th WAIT cycle -> WB, no error.
- Illegal opcode 0x7000 -> ERR. Separately, `rst_n` low during WAIT -> all outputs 0 asynchronously, FSM IDLE.

Source files
------------

// File: rtl/dp_sequencer.sv
// dp_sequencer
// Multi-cycle control unit for the data_path block. Fetches a 16-bit
// instruction, decodes it, then steps data_path through operand read,
// ALU execution, register writeback and PC update. A watchdog counter
// catches a datapath that never raises its completion strobe.
//
// Ports:
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   start           : level start / resume request (IDLE and HALT only)
//   instr           : instruction word from instruction memory
//   instr_valid     : instr is valid this cycle
//   instr_req       : fetch request, high only in FETCH
//   dp_done         : data_path completion strobe, observed only in WAIT
//   en_in           : one-cycle datapath operation start (EXEC)
//   en_pc_pulse     : one-cycle PC update pulse (PCUP)
//   pc_ctrl         : 00 hold, 01 PC+1, 10 load offset_addr (nonzero only in PCUP)
//   offset_addr     : jump target, IR[7:0]
//   offset          : immediate operand, IR[7:0]
//   rd, rs          : destination / source register, IR[11:10] / IR[9:8]
//   alu_in_sel      : 0 = register rs, 1 = immediate
//   alu_func        : ALU function code
//   reg_en          : one-hot register write enable (WB)
//   busy            : high outside IDLE, HALT and ERR
//   halted          : high in HALT
//   error           : high in ERR (sticky until reset)

module dp_sequencer #(
    parameter int DWIDTH  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DWIDTH-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_req,
    input  logic              dp_done,
    output logic              en_in,
    output logic              en_pc_pulse,
    output logic [1:0]        pc_ctrl,
    output logic [7:0]        offset_addr,
    output logic [7:0]        offset,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic              alu_in_sel,
    output logic [2:0]        alu_func,
    output logic [3:0]        reg_en,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WAIT,
        WB,
        PCUP,
        HALT,
        ERR
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b1000;
    localparam logic [3:0] OP_SUBI = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Last WAIT count value before the watchdog gives up.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [DWIDTH-1:0] ir;
    logic [7:0]        wait_cnt;

    logic [3:0] opcode;
    logic       is_alu_reg;
    logic       is_alu_imm;

    assign opcode     = ir[15:12];
    assign is_alu_reg = (opcode >= OP_ADD) && (opcode <= OP_XOR);
    assign is_alu_imm = (opcode == OP_ADDI) || (opcode == OP_SUBI);

    // State register. Reset takes effect immediately, so every strobe
    // decoded from the state drops the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Instruction register: only a valid word presented during FETCH is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (state == FETCH && instr_valid) begin
            ir <= instr;
        end
    end

    // Watchdog counter: cleared in EXEC, counts WAIT cycles without dp_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == EXEC) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !dp_done) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Next-state logic. In the final WAIT cycle a dp_done still wins over
    // the timeout because it is tested first.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start) next_state = FETCH;
            FETCH:  if (instr_valid) next_state = DECODE;
            DECODE: begin
                if (is_alu_reg || is_alu_imm) begin
                    next_state = EXEC;
                end else if (opcode == OP_NOP || opcode == OP_JMP) begin
                    next_state = PCUP;
                end else if (opcode == OP_HALT) begin
                    next_state = HALT;
                end else begin
                    next_state = ERR;
                end
            end
            EXEC:   next_state = WAIT;
            WAIT: begin
                if (dp_done) begin
                    next_state = WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = ERR;
                end
            end
            WB:     next_state = PCUP;
            PCUP:   next_state = FETCH;
            HALT:   if (start) next_state = PCUP;
            ERR:    next_state = ERR;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from state and IR only. IR is frozen outside FETCH,
    // so the operand fields stay stable from EXEC through WB. In PCUP the
    // IR still holds the instruction that led there: JMP loads the target,
    // everything else (NOP, ALU writeback, HALT resume) steps to PC+1.
    always_comb begin
        instr_req   = 1'b0;
        en_in       = 1'b0;
        en_pc_pulse = 1'b0;
        pc_ctrl     = 2'b00;
        reg_en      = 4'b0000;
        busy        = 1'b1;
        halted      = 1'b0;
        error       = 1'b0;
        alu_func    = 3'b000;
        alu_in_sel  = 1'b0;

        rd          = ir[11:10];
        rs          = ir[9:8];
        offset      = ir[7:0];
        offset_addr = ir[7:0];

        if (is_alu_reg) begin
            alu_func = 3'(opcode - OP_ADD);
        end else if (is_alu_imm) begin
            alu_func   = (opcode == OP_SUBI) ? 3'b001 : 3'b000;
            alu_in_sel = 1'b1;
        end

        case (state)
            IDLE:  busy = 1'b0;
            FETCH: instr_req = 1'b1;
            EXEC:  en_in = 1'b1;
            WB:    reg_en = 4'b0001 << ir[11:10];
            PCUP: begin
                en_pc_pulse = 1'b1;
                pc_ctrl     = (opcode == OP_JMP) ? 2'b10 : 2'b01;
            end
            HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            ERR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer
// Self-checking bench for dp_sequencer. A table of instruction records is
// streamed through the sequencer back to back; each record carries the
// fetch latency, the dp_done latency and the hand-computed control values
// and cycle count. HALT/resume, timeout, illegal opcode and asynchronous
// reset are exercised by hand-written sequences afterwards.

module tb_dp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_req;
    logic        dp_done = 1'b0;
    logic        en_in;
    logic        en_pc_pulse;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic [7:0]  offset;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic        alu_in_sel;
    logic [2:0]  alu_func;
    logic [3:0]  reg_en;
    logic        busy;
    logic        halted;
    logic        error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] instr;
        int          fetch_wait;
        int          done_delay;
        bit          is_alu;
        logic [2:0]  func;
        logic        sel;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic [7:0]  imm;
        logic [3:0]  reg_en;
        logic [1:0]  pc;
        int          cycles;
    } vec_t;

    vec_t vecs[11];

    dp_sequencer #(.DWIDTH(16), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_req   (instr_req),
        .dp_done     (dp_done),
        .en_in       (en_in),
        .en_pc_pulse (en_pc_pulse),
        .pc_ctrl     (pc_ctrl),
        .offset_addr (offset_addr),
        .offset      (offset),
        .rd          (rd),
        .rs          (rs),
        .alu_in_sel  (alu_in_sel),
        .alu_func    (alu_func),
        .reg_en      (reg_en),
        .busy        (busy),
        .halted      (halted),
        .error       (error)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Safety net in case some bounded loop is ever miscoded.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] allOutputs();
        return 64'({instr_req, en_in, en_pc_pulse, pc_ctrl, offset_addr, offset,
                    rd, rs, alu_in_sel, alu_func, reg_en, busy, halted, error});
    endfunction

    task automatic doReset();
        rst_n       = 1'b0;
        start       = 1'b0;
        instr_valid = 1'b0;
        dp_done     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a FETCH cycle, present one valid word, return at
    // the following negedge, which is the DECODE cycle.
    task automatic feedInstr(input logic [15:0] w);
        bit got = 1'b0;
        for (int g = 0; g < 20 && !got; g++) begin
            @(negedge clk);
            if (instr_req) got = 1'b1;
        end
        checkOutput("fetch_request_seen", 64'(got), 64'd1);
        start       = 1'b0;
        instr       = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Runs one table record from its first FETCH cycle (k=1) through the
    // PC update pulse. Outputs are sampled on the falling edge, then the
    // memory and datapath inputs for that cycle are driven.
    task automatic applyStimulus(input vec_t v, input int idx);
        int  k = 0;
        int  e = 0;
        int  ens = 0;
        int  wbs = 0;
        int  overlap = 0;
        bit  done = 1'b0;
        string tag;
        tag = $sformatf("vec%0d", idx);
        for (int g = 0; g < 60 && !done; g++) begin
            @(negedge clk);
            if (k == 0 && instr_req) begin
                k     = 1;
                start = 1'b0;
            end else if (k > 0) begin
                k++;
            end

            if ($countones({en_in, en_pc_pulse, |reg_en}) > 1) overlap++;

            if (en_in) begin
                ens++;
                e = k;
                checkOutput({tag, "_alu_func"},   64'(alu_func),   64'(v.func));
                checkOutput({tag, "_alu_in_sel"}, 64'(alu_in_sel), 64'(v.sel));
                checkOutput({tag, "_rd"},         64'(rd),         64'(v.rd));
                checkOutput({tag, "_rs"},         64'(rs),         64'(v.rs));
                checkOutput({tag, "_offset"},     64'(offset),     64'(v.imm));
            end
            if (reg_en != 4'b0000) begin
                wbs++;
                checkOutput({tag, "_reg_en"},      64'(reg_en),   64'(v.reg_en));
                checkOutput({tag, "_wb_alu_func"}, 64'(alu_func), 64'(v.func));
            end
            if (en_pc_pulse) begin
                done = 1'b1;
                checkOutput({tag, "_pc_ctrl"}, 64'(pc_ctrl), 64'(v.pc));
                checkOutput({tag, "_cycles"},  64'(k),       64'(v.cycles));
                checkOutput({tag, "_en_in_count"},  64'(ens), 64'(v.is_alu));
                checkOutput({tag, "_reg_en_count"}, 64'(wbs), 64'(v.is_alu));
                checkOutput({tag, "_strobe_overlap"}, 64'(overlap), 64'd0);
                if (v.pc == 2'b10)
                    checkOutput({tag, "_offset_addr"}, 64'(offset_addr), 64'(v.imm));
            end

            instr       = v.instr;
            instr_valid = instr_req && (k >= v.fetch_wait + 1);
            dp_done     = (e > 0) && (k == e + v.done_delay);
        end
        dp_done     = 1'b0;
        instr_valid = 1'b0;
        checkOutput({tag, "_completed"}, 64'(done), 64'd1);
    endtask

    initial begin
        int  waits;
        bit  got;

        //            instr    fw dly alu func  sel   rd    rs    imm    reg_en   pc    cyc
        vecs[0]  = '{16'h1600, 0, 2,  1, 3'd0, 1'b0, 2'd1, 2'd2, 8'h00, 4'b0010, 2'b01, 7};
        vecs[1]  = '{16'h8C5A, 0, 1,  1, 3'd0, 1'b1, 2'd3, 2'd0, 8'h5A, 4'b1000, 2'b01, 6};
        vecs[2]  = '{16'h2300, 0, 3,  1, 3'd1, 1'b0, 2'd0, 2'd3, 8'h00, 4'b0001, 2'b01, 8};
        vecs[3]  = '{16'h3900, 2, 1,  1, 3'd2, 1'b0, 2'd2, 2'd1, 8'h00, 4'b0100, 2'b01, 8};
        vecs[4]  = '{16'h4500, 0, 1,  1, 3'd3, 1'b0, 2'd1, 2'd1, 8'h00, 4'b0010, 2'b01, 6};
        vecs[5]  = '{16'h5E00, 1, 1,  1, 3'd4, 1'b0, 2'd3, 2'd2, 8'h00, 4'b1000, 2'b01, 7};
        vecs[6]  = '{16'h9881, 0, 1,  1, 3'd1, 1'b1, 2'd2, 2'd0, 8'h81, 4'b0100, 2'b01, 6};
        vecs[7]  = '{16'h0000, 0, 1,  0, 3'd0, 1'b0, 2'd0, 2'd0, 8'h00, 4'b0000, 2'b01, 3};
        vecs[8]  = '{16'hC03C, 1, 1,  0, 3'd0, 1'b0, 2'd0, 2'd0, 8'h3C, 4'b0000, 2'b10, 4};
        vecs[9]  = '{16'h1800, 0, 15, 1, 3'd0, 1'b0, 2'd2, 2'd0, 8'h00, 4'b0100, 2'b01, 20};
        vecs[10] = '{16'h1600, 0, 14, 1, 3'd0, 1'b0, 2'd1, 2'd2, 8'h00, 4'b0010, 2'b01, 19};

        // Reset state, before any clock edge and after one.
        #1 rst_n = 1'b0;
        #2 checkOutput("reset_outputs_async", allOutputs(), 64'd0);
        @(negedge clk);
        checkOutput("reset_outputs_clocked", allOutputs(), 64'd0);
        doReset();

        // Start, then stream the table back to back.
        start = 1'b1;
        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // HALT: idle with halted high until start, then resume at PC+1.
        feedInstr(16'hF000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("halt_halted", 64'(halted), 64'd1);
            checkOutput("halt_busy_req", 64'({busy, instr_req}), 64'd0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("halt_resume_pulse", 64'({en_pc_pulse, pc_ctrl}), 64'b101);
        @(negedge clk);
        checkOutput("halt_resume_fetch", 64'(instr_req), 64'd1);

        // Timeout: dp_done never arrives, ERR after exactly 15 WAIT cycles.
        feedInstr(16'h1600);
        @(negedge clk);
        checkOutput("timeout_en_in", 64'(en_in), 64'd1);
        waits = 0;
        got   = 1'b0;
        for (int g = 0; g < 40 && !got; g++) begin
            @(negedge clk);
            if (error) got = 1'b1;
            else       waits++;
        end
        checkOutput("timeout_wait_cycles", 64'(waits), 64'd15);
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            @(negedge clk);
            checkOutput("err_sticky", 64'({error, busy, instr_req}), 64'b100);
        end

        // Illegal opcode goes straight to ERR from DECODE.
        doReset();
        start = 1'b1;
        feedInstr(16'h7000);
        @(negedge clk);
        checkOutput("illegal_error", 64'({error, busy, en_in}), 64'b100);

        // Asynchronous reset in the middle of WAIT.
        doReset();
        start = 1'b1;
        feedInstr(16'h1600);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 checkOutput("midwait_reset_outputs", allOutputs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_idle", 64'({busy, instr_req, error}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
